mem_arbiter: RTL

Two-port memory arbiter between the instruction cache and data cache on one side and the single shared 128-bit block memory on the other. Each cache sees a private, protocol-identical memory port (read/write strobes held until a one-cycle ready). The arbiter serialises block transfers with round-robin priority, latches the winning request, and routes the memory response back to the winner only.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between the I-cache and D-cache ports.
// The winning request is latched at grant; the memory response is routed to the winner only.
module mem_arbiter #(
  parameter int AW = 28,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ic_read,
  input  logic          ic_write,
  input  logic [AW-1:0] ic_addr,
  input  logic [DW-1:0] ic_wdata,
  output logic [DW-1:0] ic_rdata,
  output logic          ic_ready,
  input  logic          dc_read,
  input  logic          dc_write,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic [DW-1:0] dc_rdata,
  output logic          dc_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          last_gnt_r;   // 1 = D-cache served last
  logic          op_we_r;
  logic [AW-1:0] op_addr_r;
  logic [DW-1:0] op_wdata_r;

  logic req_i_s;
  logic req_d_s;
  logic grant_s;
  logic pick_d_s;
  logic gnt_s;

  assign req_i_s = ic_read | ic_write;
  assign req_d_s = dc_read | dc_write;

  // Next-state and grant decision
  always_comb begin
    state_s  = state_r;
    grant_s  = 1'b0;
    pick_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i_s && req_d_s) begin
          grant_s  = 1'b1;
          pick_d_s = ~last_gnt_r;
        end else if (req_d_s) begin
          grant_s  = 1'b1;
          pick_d_s = 1'b1;
        end else if (req_i_s) begin
          grant_s  = 1'b1;
          pick_d_s = 1'b0;
        end else begin
          grant_s  = 1'b0;
          pick_d_s = 1'b0;
        end
        if (grant_s) begin
          state_s = pick_d_s ? GNT_D : GNT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Memory strobes drop in the ready cycle so the memory never sees a second request
  always_comb begin
    gnt_s     = (state_r == GNT_I) || (state_r == GNT_D);
    mem_read  = gnt_s & ~op_we_r & ~mem_ready;
    mem_write = gnt_s & op_we_r & ~mem_ready;
    ic_ready  = (state_r == GNT_I) & mem_ready;
    dc_ready  = (state_r == GNT_D) & mem_ready;
    mem_addr  = op_addr_r;
    mem_wdata = op_wdata_r;
    ic_rdata  = mem_rdata;
    dc_rdata  = mem_rdata;
  end

  // State, round-robin history and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b0;
      op_we_r    <= 1'b0;
      op_addr_r  <= {AW{1'b0}};
      op_wdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        last_gnt_r <= pick_d_s;
        op_we_r    <= pick_d_s ? dc_write : ic_write;
        op_addr_r  <= pick_d_s ? dc_addr  : ic_addr;
        op_wdata_r <= pick_d_s ? dc_wdata : ic_wdata;
      end else begin
        last_gnt_r <= last_gnt_r;
        op_we_r    <= op_we_r;
        op_addr_r  <= op_addr_r;
        op_wdata_r <= op_wdata_r;
      end
    end
  end

endmodule
